dac_seq: RTL
============

DAC_SEQ -- requirements
Module: dac_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, sample FIFO depth; power of two, 4..16.
REQ-002 SHALL have parameter DW, default 10, sample width matching the segmented DAC controller input.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  playback enable, level-sensitive.
REQ-006 SHALL have port div  input  8  sample period minus one, in clk cycles.
REQ-007 SHALL have port wr_valid  input  1  sample write request.
REQ-008 SHALL have port wr_data  input  DW  sample to enqueue.
REQ-009 SHALL have port wr_ready  output  1  FIFO can accept; equals not-full.
REQ-010 SHALL have port clr_err  input  1  single-cycle clear of underrun flag.
REQ-011 SHALL have port dac_in  output  DW  registered sample to the DAC controller.
REQ-012 SHALL have port dac_strobe  output  1  one-cycle pulse when dac_in takes a new FIFO sample.
REQ-013 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port underrun  output  1  sticky underrun flag.
REQ-015 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-016 SHALL implement a DEPTH-entry FIFO; a write SHALL occur when wr_valid and wr_ready are both high, in any state.
REQ-017 SHALL compute wr_ready from the registered level only; when full, no write SHALL occur even on a pop cycle.
REQ-018 On a write and a pop in the same cycle with level nonzero, level SHALL stay unchanged and both SHALL complete.
REQ-019 SHALL implement states IDLE, PRIME, RUN, UNDER.
REQ-020 IDLE->PRIME when en=1; PRIME->RUN when level>=DEPTH/2; RUN->UNDER on a tick with level=0; UNDER->PRIME on the next cycle.
REQ-021 When en=0, any state SHALL go to IDLE on the next edge; the divider SHALL clear; FIFO contents and dac_in SHALL be retained.
REQ-022 The divider SHALL count only in RUN, starting from 0 on RUN entry, and SHALL produce a tick when count>=div, then return to 0; div=0 SHALL give a tick every cycle.
REQ-023 A div change mid-run SHALL take effect on the current count (>= compare), with no wrap past 255.
REQ-024 On a tick with level>0, the FIFO head SHALL be popped into dac_in with dac_strobe=1 in the same registered cycle; dac_in changes exactly one cycle after the tick.
REQ-025 On a tick with level=0 (the pre-write value), underrun SHALL set; a write in that cycle SHALL still be accepted.
REQ-026 clr_err SHALL clear underrun; a simultaneous set SHALL take priority.
REQ-027 dac_strobe SHALL be 0 outside RUN ticks.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, FIFO empty (level 0), divider 0, dac_in 0, dac_strobe 0, underrun 0, busy 0, wr_ready 1.
REQ-029 Reset mid-operation SHALL discard all FIFO contents; no strobe SHALL be emitted on the first edge after release.

Configuration
REQ-030 With macro DAC_SEQ_MIDSCALE_EN defined, entry to UNDER SHALL load dac_in with 2^(DW-1) (512 for DW=10), without a strobe.
REQ-031 Without DAC_SEQ_MIDSCALE_EN, dac_in SHALL hold its last value through UNDER.

Verification
REQ-032 Reset, en=1, div=3, write 4 samples 100..103 -> busy=1, PRIME->RUN at level 4, dac_in steps 100,101,102,103 with one strobe every 4 cycles.
REQ-033 Write 8 samples with en=0 -> wr_ready=0 and level=8; a 9th wr_valid is ignored; level stays 8.
REQ-034 RUN with div=0 and the FIFO drained -> underrun=1, state UNDER then PRIME; dac_in=512 with the macro, else the last sample.
REQ-035 clr_err pulse in the same cycle as a new underrun -> underrun remains 1; a later lone clr_err -> 0.
REQ-036 Drop en mid-RUN, then raise it -> IDLE, retained level and dac_in, re-enter PRIME, resume from the next FIFO entry.
REQ-037 Assert rst_n low mid-RUN, asynchronously to clk -> all outputs take their reset values immediately, and level=0.

Source files
------------

// File: rtl/dac_seq.sv
// dac_seq: sample FIFO feeding a segmented DAC controller at a programmable sample rate.
// Optional feature: define DAC_SEQ_MIDSCALE_EN to park dac_in at mid-scale on underrun.
module dac_seq #(
  parameter int DEPTH = 8,
  parameter int DW    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [7:0]             div,
  input  logic                   wr_valid,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   clr_err,
  output logic [DW-1:0]          dac_in,
  output logic                   dac_strobe,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);
  localparam logic [LW-1:0] ZERO_LVL = {LW{1'b0}};
`ifdef DAC_SEQ_MIDSCALE_EN
  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    UNDER = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    cnt;
  logic [7:0]    cnt_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          tick;
  logic          do_wr;
  logic          do_pop;
  logic          starve;

  assign wr_ready = (level != FULL_LVL);
  assign busy     = (state != IDLE);

  // Divider, FIFO handshake and next-state decode
  always_comb begin
    tick      = 1'b0;
    cnt_nxt   = 8'd0;
    state_nxt = state;
    if (en && (state == RUN)) begin
      // >= compare lets a lowered div fire at once; the counter can never pass 255
      tick    = (cnt >= div);
      cnt_nxt = tick ? 8'd0 : (cnt + 8'd1);
    end else begin
      tick    = 1'b0;
      cnt_nxt = 8'd0;
    end
    do_wr  = wr_valid && wr_ready;
    do_pop = tick && (level != ZERO_LVL);
    starve = tick && (level == ZERO_LVL);
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   state_nxt = (level >= HALF_LVL) ? RUN : PRIME;
        RUN:     state_nxt = starve ? UNDER : RUN;
        UNDER:   state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sample storage; contents are invalidated by the pointer reset, not cleared
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      level <= ZERO_LVL;
    end else begin
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      level <= level + LW'(do_wr) - LW'(do_pop);
    end
  end

  // DAC output register, strobe and sticky underrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_in     <= {DW{1'b0}};
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dac_strobe <= do_pop;
      if (do_pop) begin
        dac_in <= mem[rptr];
      end
`ifdef DAC_SEQ_MIDSCALE_EN
      else if (starve) begin
        dac_in <= MIDSCALE;
      end
`endif
      if (starve) begin
        underrun <= 1'b1;
      end else if (clr_err) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
